pipe_referee: RTL and testbench

PIPE_REFEREE -- requirements
Module: pipe_referee

---
 rtl/referee_pkg.sv | 11 +
 rtl/pipe_pass_detect.sv | 26 ++
 rtl/pipe_referee.sv | 79 +++++++
 tb/tb_pipe_referee.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/referee_pkg.sv
// referee_pkg: shared state encoding, key codes and helpers for pipe_referee
package referee_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, HIT = 2'd2, OVER = 2'd3} state_e;
  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_R = 8'h15;
  localparam int NUM_PIPES = 3;
  localparam logic [26:0] SCORE_MAX = 27'h7FFFFFF;
  function automatic logic signed [11:0] sx(input logic [9:0] v);
    return signed'({2'b00, v});
  endfunction
endpackage

// File: rtl/pipe_pass_detect.sv
// pipe_pass_detect: per-pipe ahead tracking, pass pulse and bird/pipe x-overlap
module pipe_pass_detect
  import referee_pkg::*;
#(
  parameter logic [9:0] PIPE_W = 10'd20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [9:0] bird_x,
  input  logic [9:0] bird_s,
  input  logic [9:0] pipe_x,
  output logic       pass,
  output logic       overlap
);
  logic [10:0] right;
  logic ahead, ahead_q;
  assign right = {1'b0, pipe_x} + {1'b0, PIPE_W};
  assign ahead = right >= {1'b0, bird_x};
  assign pass = en && ahead_q && !ahead;
  assign overlap = (sx(bird_x) + sx(bird_s) >= sx(pipe_x)) &&
                   (sx(bird_x) - sx(bird_s) <= signed'({1'b0, right}));
  // remember whether the pipe was still ahead of the bird last frame; a respawn only sets it
  always_ff @(posedge clk)
    ahead_q <= rst ? 1'b1 : ahead;
endmodule

// File: rtl/pipe_referee.sv
// pipe_referee: scoring and crash referee for the flappy-pipe game (optional best score: REFEREE_BEST_SCORE_EN)
module pipe_referee
  import referee_pkg::*;
#(
  parameter logic [9:0] PIPE_W     = 10'd20,
  parameter logic [9:0] GAP_HALF   = 10'd60,
  parameter logic [9:0] GROUND_Y   = 10'd470,
  parameter logic [5:0] HIT_FRAMES = 6'd30
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic [7:0]  keycode,
  input  logic [9:0]  BirdX,
  input  logic [9:0]  BirdY,
  input  logic [9:0]  BirdS,
  input  logic [9:0]  PipeX [NUM_PIPES],
  input  logic [9:0]  PipeY [NUM_PIPES],
  output logic [26:0] score,
  output logic [26:0] best_score,
  output logic [1:0]  state,
  output logic        hit_pulse,
  output logic        game_over
);
  state_e st, nx;
  logic [5:0] cnt;
  logic [NUM_PIPES-1:0] pass, ovl, gap_miss;
  logic [1:0] npass;
  logic [27:0] sum;
  logic coll, hit_d, over_d;
  for (genvar i = 0; i < NUM_PIPES; i++) begin : g_pipe
    pipe_pass_detect #(.PIPE_W(PIPE_W)) u_det (
      .clk(frame_clk), .rst(Reset), .en(st == PLAY),
      .bird_x(BirdX), .bird_s(BirdS), .pipe_x(PipeX[i]),
      .pass(pass[i]), .overlap(ovl[i])
    );
    assign gap_miss[i] = (sx(BirdY) - sx(BirdS) < sx(PipeY[i]) - sx(GAP_HALF)) ||
                         (sx(BirdY) + sx(BirdS) > sx(PipeY[i]) + sx(GAP_HALF));
  end
  assign coll = |(ovl & gap_miss) || (sx(BirdY) + sx(BirdS) >= sx(GROUND_Y)) || (BirdY < BirdS);
  assign npass = 2'($countones(pass));
  assign sum = {1'b0, score} + {26'd0, npass};
  assign state = st;
  // next-state: keys only matter in IDLE and OVER
  always_comb
    nx = st == IDLE ? (keycode == KEY_W ? PLAY : IDLE) :
         st == PLAY ? (coll ? HIT : PLAY) :
         st == HIT  ? (cnt == HIT_FRAMES - 6'd1 ? OVER : HIT) :
                      (keycode == KEY_R ? IDLE : OVER);
  // output decode, registered below
  always_comb begin
    hit_d = st == PLAY && nx == HIT;
    over_d = nx == OVER;
  end
  // state, flag and hit-frame counter registers
  always_ff @(posedge frame_clk)
    if (Reset) begin
      st <= IDLE;
      cnt <= '0;
      hit_pulse <= 1'b0;
      game_over <= 1'b0;
    end else begin
      st <= nx;
      cnt <= st == HIT ? cnt + 6'd1 : '0;
      hit_pulse <= hit_d;
      game_over <= over_d;
    end
  // score clears on game start and only counts during PLAY, saturating at the top
  always_ff @(posedge frame_clk)
    if (Reset || (st == IDLE && nx == PLAY)) score <= '0;
    else if (st == PLAY) score <= sum[27] ? SCORE_MAX : sum[26:0];
`ifdef REFEREE_BEST_SCORE_EN
  // best score captured as the hit animation finishes
  always_ff @(posedge frame_clk)
    if (Reset) best_score <= '0;
    else if (st == HIT && nx == OVER && score > best_score) best_score <= score;
`else
  assign best_score = '0;
`endif
endmodule

// File: tb/tb_pipe_referee.sv
// tb_pipe_referee: directed plus random checks of pipe_referee against a frame-level game model
module tb_pipe_referee;
  logic clk = 1'b0;
  logic rst;
  logic [7:0] key;
  logic [9:0] bx, by, bs;
  logic [9:0] px [3];
  logic [9:0] py [3];
  logic [26:0] score, best;
  logic [1:0] state;
  logic hp, go;
  int n_chk = 0, n_fail = 0;
  int m_state, m_score, m_best, m_frames, m_hp;
  bit m_ahead [3];
  always #5 clk = ~clk;
  pipe_referee dut (
    .frame_clk(clk), .Reset(rst), .keycode(key),
    .BirdX(bx), .BirdY(by), .BirdS(bs), .PipeX(px), .PipeY(py),
    .score(score), .best_score(best), .state(state), .hit_pulse(hp), .game_over(go)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  // what one frame edge does to the game, given the inputs presented before it
  task automatic model_edge();
    int bxi, byi, bsi, pxi, pyi, passes;
    bit coll;
    bit now [3];
    if (rst) begin
      m_state = 0; m_score = 0; m_best = 0; m_frames = 0; m_hp = 0;
      m_ahead = '{1'b1, 1'b1, 1'b1};
    end else begin
      bxi = int'(bx); byi = int'(by); bsi = int'(bs);
      passes = 0;
      coll = (byi + bsi >= 470) || (byi < bsi);
      for (int i = 0; i < 3; i++) begin
        pxi = int'(px[i]); pyi = int'(py[i]);
        now[i] = pxi + 20 >= bxi;
        if (m_state == 1 && m_ahead[i] && !now[i]) passes++;
        if (bxi + bsi >= pxi && bxi - bsi <= pxi + 20 &&
            (byi - bsi < pyi - 60 || byi + bsi > pyi + 60)) coll = 1;
      end
      m_hp = 0;
      if (m_state == 0) begin
        if (key == 8'h1A) begin m_state = 1; m_score = 0; end
      end else if (m_state == 1) begin
        m_score = (m_score + passes > 134217727) ? 134217727 : m_score + passes;
        if (coll) begin m_state = 2; m_frames = 0; m_hp = 1; end
      end else if (m_state == 2) begin
        m_frames++;
        if (m_frames == 30) begin
          m_state = 3;
`ifdef REFEREE_BEST_SCORE_EN
          if (m_score > m_best) m_best = m_score;
`endif
        end
      end else if (key == 8'h15) m_state = 0;
      m_ahead = now;
    end
  endtask
  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    chk({tag, ".state"}, 32'(state), m_state);
    chk({tag, ".score"}, 32'(score), m_score);
    chk({tag, ".hit_pulse"}, 32'(hp), m_hp);
    chk({tag, ".game_over"}, 32'(go), 32'(m_state == 3));
    chk({tag, ".best"}, 32'(best), m_best);
  endtask
  task automatic safe();
    bx = 10'd100; by = 10'd240; bs = 10'd4;
    px = '{10'd300, 10'd500, 10'd639};
    py = '{10'd240, 10'd240, 10'd240};
  endtask
  task automatic pass0();
    px[0] = 10'd81; step("pre");
    px[0] = 10'd79; step("cross");
  endtask
  task automatic crash_to_idle();
    by = 10'd466; step("crash");
    by = 10'd240;
    repeat (30) step("hit");
    key = 8'h15; step("restart"); key = 8'h00;
  endtask
  task automatic play_game(input int n);
    safe(); key = 8'h1A; step("go"); key = 8'h00;
    repeat (n) pass0();
    crash_to_idle();
  endtask
  initial begin
    rst = 1'b1; key = 8'h00; safe();
    step("reset");
    chk("reset_state", 32'(state), 0);
    chk("reset_score", 32'(score), 0);
    rst = 1'b0;
    key = 8'h1A; step("start"); key = 8'h00;
    chk("start_state", 32'(state), 1);
    chk("start_score", 32'(score), 0);
    px[0] = 10'd81; step("p81");
    px[0] = 10'd79; step("p79");
    chk("single_pass", 32'(score), 1);
    px[1] = 10'd85; px[2] = 10'd85; step("two_pre");
    px[1] = 10'd70; px[2] = 10'd70; step("two_cross");
    chk("double_pass", 32'(score), 3);
    px[0] = 10'd0; step("p0");
    px[0] = 10'd639; step("respawn");
    chk("respawn_no_inc", 32'(score), 3);
    key = 8'h15; step("r_in_play"); key = 8'h00;
    chk("r_ignored", 32'(state), 1);
    by = 10'd466; step("ground");
    chk("ground_pulse", 32'(hp), 1);
    chk("ground_state", 32'(state), 2);
    by = 10'd240;
    step("hit1");
    chk("pulse_one_cycle", 32'(hp), 0);
    repeat (28) step("hit");
    chk("still_hit", 32'(state), 2);
    step("hit30");
    chk("over_state", 32'(state), 3);
    chk("over_flag", 32'(go), 1);
    key = 8'h15; step("to_idle"); key = 8'h00;
    chk("idle_again", 32'(state), 0);
    play_game(5);
    play_game(3);
`ifdef REFEREE_BEST_SCORE_EN
    chk("best_score", 32'(best), 5);
`else
    chk("best_score", 32'(best), 0);
`endif
    safe(); key = 8'h1A; step("go2"); key = 8'h00;
    px[0] = 10'd81; step("pre2");
    px[0] = 10'd79; by = 10'd466; step("pass_and_crash");
    chk("coinc_score", 32'(score), 1);
    chk("coinc_state", 32'(state), 2);
    by = 10'd240;
    repeat (3) step("hit");
    rst = 1'b1; step("reset_in_hit"); rst = 1'b0;
    chk("rst_hit_state", 32'(state), 0);
    chk("rst_hit_score", 32'(score), 0);
    for (int n = 0; n < 600; n++) begin
      rst = $urandom_range(0, 99) == 0;
      case ($urandom_range(0, 3))
        0: key = 8'h1A;
        1: key = 8'h15;
        2: key = 8'h00;
        default: key = 8'($urandom);
      endcase
      if ($urandom_range(0, 3) != 0) begin
        bx = 10'($urandom_range(100, 140));
        by = 10'($urandom_range(200, 280));
        bs = 10'($urandom_range(2, 8));
        for (int i = 0; i < 3; i++) begin
          px[i] = 10'($urandom_range(0, 639));
          py[i] = by;
        end
      end else begin
        bx = 10'($urandom_range(0, 639));
        by = 10'($urandom_range(0, 479));
        bs = 10'($urandom_range(1, 15));
        for (int i = 0; i < 3; i++) begin
          px[i] = 10'($urandom_range(0, 639));
          py[i] = 10'($urandom_range(80, 400));
        end
      end
      step("rand");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
